// File: rtl/sched_assign_unit.sv
// Delayed-assignment scheduler: each request updates dout exactly DELAY clocks later,
// capturing din either at request time (mode 0) or at expiry (mode 1).
module sched_assign_unit #(
  parameter int WIDTH = 8,
  parameter int DELAY = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             upd,
  output logic             busy,
  output logic             full,
  output logic             ovf
);

  localparam int RW    = $clog2(DELAY + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NSLOT = 2 ** PW;
  localparam logic [RW-1:0] REM_INIT = RW'(DELAY - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Storage is rounded up to a power of two so pointer indexing is always in range;
  // pointers still wrap at DEPTH, so any extra slots stay unused.
  logic [NSLOT-1:0] vld;
  logic [NSLOT-1:0] ent_mode;
  logic [WIDTH-1:0] ent_data [NSLOT];
  logic [RW-1:0]    ent_rem  [NSLOT];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             retire;
  logic             accept;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign busy   = (count != '0);
  assign full   = (count == CNT_FULL);
  assign retire = vld[rd_ptr] && (ent_rem[rd_ptr] == '0);
  assign accept = req && (!full || retire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      upd      <= 1'b0;
      ovf      <= 1'b0;
      vld      <= '0;
      ent_mode <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        ent_data[i] <= '0;
        ent_rem[i]  <= '0;
      end
    end else begin
      upd <= retire;
      ovf <= req && !accept;

      for (int i = 0; i < NSLOT; i++) begin
        if (vld[i] && (ent_rem[i] != '0)) ent_rem[i] <= ent_rem[i] - 1'b1;
      end

      if (retire) begin
        dout        <= ent_mode[rd_ptr] ? din : ent_data[rd_ptr];
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= ptr_next(rd_ptr);
      end

      // Placed after the retire so a slot freed and refilled on the same edge ends up valid.
      if (accept) begin
        vld[wr_ptr]      <= 1'b1;
        ent_mode[wr_ptr] <= mode;
        ent_data[wr_ptr] <= din;
        ent_rem[wr_ptr]  <= REM_INIT;
        wr_ptr           <= ptr_next(wr_ptr);
      end

      case ({accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sched_assign_unit.sv
// Scoreboard bench for sched_assign_unit: a DELAY=25/DEPTH=4 instance for the main
// scenarios and a DELAY=1/DEPTH=1 instance for back-to-back mixed-mode traffic.
module tb_sched_assign_unit;

  localparam int D = 25;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0, mode = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       upd, busy, full, ovf;

  logic       req1 = 1'b0, mode1 = 1'b0;
  logic [7:0] din1 = 8'h00;
  logic [7:0] dout1;
  logic       upd1, busy1, full1, ovf1;

  sched_assign_unit #(.WIDTH(8), .DELAY(D), .DEPTH(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .din(din),
    .dout(dout), .upd(upd), .busy(busy), .full(full), .ovf(ovf));

  sched_assign_unit #(.WIDTH(8), .DELAY(1), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .mode(mode1), .din(din1),
    .dout(dout1), .upd(upd1), .busy(busy1), .full(full1), .ovf(ovf1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       m;
    logic [7:0] d;
    int         due;
  } ent_t;

  ent_t       sb[$];
  int         cyc = 0;
  logic [7:0] din_hist [1024];
  logic       ovf_pred [1024];
  logic [7:0] exp_dout = 8'h00;
  bit         mon_en = 1'b0;

  always @(posedge clk) begin
    din_hist[cyc % 1024] <= din;
    cyc <= cyc + 1;
  end

  int   last;
  logic eu;
  always @(negedge clk) begin
    if (mon_en) begin
      last = cyc - 1;
      eu   = 1'b0;
      if (sb.size() > 0 && sb[0].due <= last) begin
        eu       = 1'b1;
        exp_dout = sb[0].m ? din_hist[last % 1024] : sb[0].d;
        void'(sb.pop_front());
      end
      chk("upd", upd, eu);
      chk("dout", dout, exp_dout);
      chk("ovf", ovf, ovf_pred[last % 1024]);
      ovf_pred[last % 1024] = 1'b0;
      chk("busy", busy, sb.size() != 0);
      chk("full", full, sb.size() == N);
    end
  end

  // One edge of stimulus; the model predicts accept/drop for the coming edge.
  task automatic step(input logic r, input logic m, input logic [7:0] d);
    int ed;
    bit rn;
    @(negedge clk);
    #1;
    req  = r;
    mode = m;
    din  = d;
    ed   = cyc;
    if (r) begin
      rn = (sb.size() > 0) && (sb[0].due == ed);
      if (sb.size() < N || rn) begin
        sb.push_back('{m: m, d: d, due: ed + D});
        ovf_pred[ed % 1024] = 1'b0;
      end else begin
        ovf_pred[ed % 1024] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input logic [7:0] d);
    repeat (n) step(1'b0, 1'b0, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req   = 1'b0;
    sb.delete();
    for (int i = 0; i < 1024; i++) ovf_pred[i] = 1'b0;
    exp_dout = 8'h00;
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_upd", upd, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] d6 [16];
  logic       m6 [16];

  initial begin
    for (int i = 0; i < 1024; i++) ovf_pred[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_dout", dout, 8'h00);
    chk("init_upd", upd, 1'b0);
    chk("init_ovf", ovf, 1'b0);
    chk("init_busy", busy, 1'b0);
    chk("init_full", full, 1'b0);
    chk("init_busy1", busy1, 1'b0);
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // intra-assignment: value captured at request
    step(1'b1, 1'b0, 8'h01);
    idle(8, 8'h01);
    idle(30, 8'h00);

    // regular delay: value captured at expiry
    do_reset();
    step(1'b1, 1'b1, 8'h01);
    idle(8, 8'h01);
    idle(30, 8'h00);

    // back-to-back fill
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    idle(30, 8'h00);

    // overflow at edge 5, accept while head retires at edge 26
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    step(1'b1, 1'b0, 8'h55);
    idle(20, 8'h00);
    step(1'b1, 1'b0, 8'hA5);
    idle(30, 8'h00);

    // reset mid-flight with dout non-zero and three requests pending
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h30 + i));
    idle(8, 8'h3C);
    do_reset();
    idle(50, 8'h77);

    // DELAY=1, DEPTH=1: every-edge requests with alternating mode
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      #1;
      if (i >= 2) begin
        chk("t6_upd", upd1, 1'b1);
        chk("t6_dout", dout1, m6[i-2] ? d6[i-1] : d6[i-2]);
      end
      if (i >= 1) chk("t6_ovf", ovf1, 1'b0);
      if (i < 12) begin
        req1  = 1'b1;
        mode1 = i[0];
        din1  = 8'(i * 3 + 1);
      end else begin
        req1 = 1'b0;
      end
      d6[i] = din1;
      m6[i] = mode1;
    end
    idle(3, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sched_assign_unit.md
Name: sched_assign_unit

Overview:
Synthesizable hardware counterpart of the intra-assignment-delay and regular-delay assignment semantics.
- Each request schedules one update of `dout` exactly DELAY clocks later.
- The source value is sampled either at request time (intra-assignment, "sample now, apply later") or at expiry time (regular delay, "wait, then sample").
- Up to DEPTH requests may be outstanding. They retire in issue order.
- Sits between stimulus/control logic and any register that needs deterministic delayed updates.

Parameters:
- WIDTH, 8: data width of `din`/`dout`.
- DELAY, 25: clocks from request acceptance to `dout` update; legal range >= 1.
- DEPTH, 4: maximum outstanding requests; legal range >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  request strobe, sampled each rising edge.
- mode  input  1  0 = intra-assignment (capture `din` at request); 1 = regular delay (capture `din` at expiry). Sampled with `req`.
- din  input  WIDTH  source value.
- dout  output  WIDTH  scheduled destination register.
- upd  output  1  high for the one cycle following each `dout` update edge.
- busy  output  1  one or more requests outstanding.
- full  output  1  DEPTH requests outstanding.
- ovf  output  1  one-cycle strobe: a request was dropped.

Behaviour:
- Reset: asserting `rst_n` low immediately (asynchronously) sets:
  - `dout` = 0, `upd` = 0, `ovf` = 0;
  - queue empty, so `busy` = 0 and `full` = 0;
  - all countdowns cleared.
  - Reset mid-operation discards all pending requests; no `upd` follows for them.
- Queue:
  - Circular buffer of DEPTH entries; each entry = {mode, data[WIDTH], remaining[clog2(DELAY+1)]}.
  - Read/write pointers wrap modulo DEPTH.
  - `busy` = (count != 0); `full` = (count == DEPTH). Both are combinational from registered count.
- Accept:
  - `req` = 1 at edge k with a free slot (`full` = 0, or the head retires at the same edge k) writes a new entry with remaining = DELAY-1.
  - If mode = 0, `din` at edge k is stored in the entry's data.
- Countdown: on every edge, all valid entries with remaining > 0 decrement by 1.
- Retire: at the edge where the head entry has remaining == 0:
  - `dout` <= stored data if mode = 0;
  - `dout` <= `din` sampled at that same edge if mode = 1;
  - head pops; `upd` = 1 for the following cycle.
- Latency: a request accepted at edge k updates `dout` at edge k+DELAY.
  - Because DELAY is fixed, retirement order equals issue order and at most one entry retires per edge.
- Drop: `req` = 1 while `full` = 1 and no retire at that edge:
  - request is discarded; `ovf` = 1 for the next cycle;
  - count, `dout` and the queue are unchanged.
- Simultaneous accept and retire: count is unchanged; both operations occur.
  - With DELAY = 1 and DEPTH = 1, back-to-back requests every edge are all accepted.
- Between updates, `dout` holds its value. `din` changes never affect `dout` except at a mode-1 retire edge.
- `mode` and `din` are ignored when `req` = 0.

Test Plan (WIDTH = 8, DELAY = 25, DEPTH = 4 unless stated):
1. Intra-assignment: `din` = 0x01 with `req` = 1, `mode` = 0 at edge 1; `din` -> 0x00 at edge 10 -> `dout` = 0x01 after edge 26; `upd` high one cycle; `busy` high over edges 1..26.
2. Regular delay: same stimulus with `mode` = 1 -> `dout` = 0x00 after edge 26; `dout` unchanged (0x00 from reset) before that edge.
3. Back-to-back: `req` at edges 1..4 with `din` 0x10..0x13, `mode` = 0 ->
   - `full` = 1 after edge 4;
   - `dout` steps 0x10, 0x11, 0x12, 0x13 at edges 26..29;
   - `upd` high for 4 consecutive cycles; `busy` = 0 after edge 29.
4. Overflow and boundary: fill as in test 3, then:
   - `req` at edge 5 -> `ovf` pulse, no `dout` change at edge 30;
   - `req` at edge 26 (head retiring) -> accepted, count stays 4, its update occurs at edge 51.
5. Reset mid-flight: 3 requests issued, `rst_n` low at edge 12 for 2 cycles -> `dout` = 0 and `busy` = 0 immediately; no `upd` through edge 60.
6. Mixed modes with DELAY = 1, DEPTH = 1: `req` every edge, alternating `mode`, `din` incrementing -> every request accepted, `ovf` never set.
   - A mode-0 request at edge k yields `dout` = `din`(k) at edge k+1.
   - A mode-1 request at edge k yields `dout` = `din`(k+1) at edge k+1.
